// File: rtl/pipeline_reg_elastic_pkg.sv
// Shared types for the elastic pipeline register: per-stage occupancy states.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipeline_reg_elastic_if.sv
// Valid/ready/payload link between adjacent elastic stages.
interface pipe_if #(
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_reg_elastic_skid_slot.sv
// One elastic stage: main + skid register, registered upstream ready.
module skid_slot
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    pipe_if.slave  up,
    pipe_if.master dn
);
    stage_state_t  r_state;
    stage_state_t  w_state_nxt;
    logic          r_ready;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          w_in;
    logic          w_out;
    logic          w_ld_main;
    logic          w_main_from_skid;
    logic          w_ld_skid;

    assign w_in     = up.valid & r_ready;
    assign w_out    = (r_state != ST_EMPTY) & dn.ready;
    assign up.ready = r_ready;
    assign dn.valid = (r_state != ST_EMPTY);
    assign dn.data  = r_main;

    always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_main_from_skid = 1'b0;
        w_ld_skid        = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in) begin
                    w_ld_main   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in && w_out) begin
                    w_ld_main = 1'b1;
                end else if (w_in) begin
                    w_ld_skid   = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_BUSY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // A kill discards everything and suppresses any load in the same cycle.
        if (flush_i) begin
            w_state_nxt      = ST_EMPTY;
            w_ld_main        = 1'b0;
            w_main_from_skid = 1'b0;
            w_ld_skid        = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_FULL);
            if (w_ld_main) begin
                r_main <= up.data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= up.data;
            end
        end
    end
endmodule

// File: rtl/pipeline_reg_elastic.sv
// Cascade of STAGES elastic skid stages with flush and a registered occupancy count.
module pipeline_reg_elastic
    import pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 1,
    parameter int CW     = $clog2(2*STAGES+1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] occ_o
);
    pipe_if #(.DW(DW)) w_link [STAGES+1] ();

    logic          w_in_xfer;
    logic          w_out_xfer;
    logic [CW-1:0] r_occ;

    assign w_link[0].valid     = valid_i;
    assign w_link[0].data      = data_i;
    assign ready_o             = w_link[0].ready;
    assign valid_o             = w_link[STAGES].valid;
    assign data_o              = w_link[STAGES].data;
    assign w_link[STAGES].ready = ready_i;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        skid_slot #(.DW(DW)) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .up      (w_link[g]),
            .dn      (w_link[g+1])
        );
    end

    assign w_in_xfer  = valid_i & ready_o;
    assign w_out_xfer = valid_o & ready_i;

    // Total entries only change at the chain ends; interior moves cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

    assign occ_o = r_occ;
endmodule

// File: tb/tb_pipeline_reg_elastic.sv
// Directed and scoreboard checks of a two-stage elastic pipeline register.
module tb_pipeline_reg_elastic;
    localparam int DW     = 32;
    localparam int STAGES = 2;
    localparam int CW     = $clog2(2*STAGES+1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic [CW-1:0] occ;
    int            n_chk;
    int            n_err;
    logic [31:0]   wbase;
    int            widx;
    logic [31:0]   q[$];

    pipe_if #(.DW(DW)) up_if ();
    pipe_if #(.DW(DW)) dn_if ();

    pipeline_reg_elastic #(.DW(DW), .STAGES(STAGES)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .valid_i (up_if.valid),
        .ready_o (up_if.ready),
        .data_i  (up_if.data),
        .valid_o (dn_if.valid),
        .ready_i (dn_if.ready),
        .data_o  (dn_if.data),
        .occ_o   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One streaming cycle: the offered word advances only once it is taken.
    task automatic stream_tick();
        logic acc;
        acc = up_if.valid & up_if.ready;
        tick();
        if (acc) widx++;
        up_if.data = wbase + widx;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        up_if.valid = 1'b0;
        up_if.data = '0;
        dn_if.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid_o", {31'd0, dn_if.valid}, 32'd0);
        check("rst_ready_o", {31'd0, up_if.ready}, 32'd1);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_data_o", dn_if.data, 32'd0);

        // Full-rate stream of eight words
        dn_if.ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            up_if.valid = (k < 8);
            up_if.data = 32'hA5A5_0001 + k;
            tick();
            check("str_valid_o", {31'd0, dn_if.valid}, {31'd0, (k >= 1 && k <= 8)});
            if (k >= 1 && k <= 8) check("str_data_o", dn_if.data, 32'hA5A5_0001 + (k - 1));
            check("str_occ", 32'(occ),
                  32'((k + 1 < 8 ? k + 1 : 8) - (k - 1 < 0 ? 0 : (k - 1 < 8 ? k - 1 : 8))));
            check("str_ready_o", {31'd0, up_if.ready}, 32'd1);
        end
        up_if.valid = 1'b0;

        // Stall: four words fill both stages, then release
        wbase = 32'hC000_0000;
        widx = 0;
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data = wbase;
        for (int k = 0; k < 6; k++) stream_tick();
        check("stall_ready_o", {31'd0, up_if.ready}, 32'd0);
        check("stall_occ", 32'(occ), 32'd4);
        check("stall_data_o", dn_if.data, 32'hC000_0000);
        check("stall_widx", 32'(widx), 32'd4);
        dn_if.ready = 1'b1;
        #1;
        check("comb_ready_hi", {31'd0, up_if.ready}, 32'd0);
        dn_if.ready = 1'b0;
        #1;
        check("comb_ready_lo", {31'd0, up_if.ready}, 32'd0);
        dn_if.ready = 1'b1;
        stream_tick();
        check("rel1_data", dn_if.data, 32'hC000_0001);
        check("rel1_occ", 32'(occ), 32'd3);
        check("rel1_ready_o", {31'd0, up_if.ready}, 32'd0);
        stream_tick();
        check("rel2_data", dn_if.data, 32'hC000_0002);
        check("rel2_occ", 32'(occ), 32'd2);
        check("rel2_ready_o", {31'd0, up_if.ready}, 32'd1);
        stream_tick();
        check("rel3_data", dn_if.data, 32'hC000_0003);
        stream_tick();
        check("rel4_data", dn_if.data, 32'hC000_0004);
        stream_tick();
        check("rel5_data", dn_if.data, 32'hC000_0005);
        check("rel5_occ", 32'(occ), 32'd2);
        up_if.valid = 1'b0;
        tick();
        check("drain1_data", dn_if.data, 32'hC000_0006);
        check("drain1_occ", 32'(occ), 32'd1);
        tick();
        check("drain2_valid_o", {31'd0, dn_if.valid}, 32'd0);
        check("drain2_occ", 32'(occ), 32'd0);

        // Flush a full pipeline while offering a word that must be dropped
        wbase = 32'hD000_0000;
        widx = 0;
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data = wbase;
        for (int k = 0; k < 6; k++) stream_tick();
        check("fl_fill_occ", 32'(occ), 32'd4);
        flush = 1'b1;
        up_if.data = 32'h0000_DEAD;
        dn_if.ready = 1'b1;
        tick();
        flush = 1'b0;
        up_if.valid = 1'b0;
        check("fl_occ", 32'(occ), 32'd0);
        check("fl_valid_o", {31'd0, dn_if.valid}, 32'd0);
        check("fl_ready_o", {31'd0, up_if.ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_no_dead", {31'd0, dn_if.valid}, 32'd0);
        end
        up_if.valid = 1'b1;
        up_if.data = 32'h0000_1234;
        tick();
        up_if.valid = 1'b0;
        check("pf_lat1_valid", {31'd0, dn_if.valid}, 32'd0);
        tick();
        check("pf_lat2_valid", {31'd0, dn_if.valid}, 32'd1);
        check("pf_lat2_data", dn_if.data, 32'h0000_1234);
        tick();

        // Reset while full and stalled
        wbase = 32'hE000_0000;
        widx = 0;
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data = wbase;
        for (int k = 0; k < 6; k++) stream_tick();
        check("rf_fill_occ", 32'(occ), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        up_if.valid = 1'b0;
        check("rf_valid_o", {31'd0, dn_if.valid}, 32'd0);
        check("rf_data_o", dn_if.data, 32'd0);
        check("rf_occ", 32'(occ), 32'd0);
        check("rf_ready_o", {31'd0, up_if.ready}, 32'd1);

        // Random handshakes against a FIFO scoreboard
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic in_x;
            logic out_x;
            up_if.valid = 1'($urandom_range(1));
            up_if.data = $urandom;
            dn_if.ready = 1'($urandom_range(1));
            #1;
            in_x = up_if.valid & up_if.ready;
            out_x = dn_if.valid & dn_if.ready;
            if (out_x) begin
                if (q.size() > 0) check("sb_data", dn_if.data, q.pop_front());
                else check("sb_spurious", {31'd0, dn_if.valid}, 32'd0);
            end
            if (in_x) q.push_back(up_if.data);
            tick();
            check("sb_occ", 32'(occ), 32'(q.size()));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
